hamming_secded_decoder: RTL and testbench



---
 rtl/hamming_pkg.sv | 50 +++++
 rtl/hamming_syndrome.sv | 27 ++
 rtl/hamming_secded_decoder.sv | 179 +++++++++++++++++
 tb/tb_hamming_secded_decoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared definitions for the extended-Hamming (SECDED) codec: error classes,
// parity-width sizing and the data-bit to codeword-position mapping.
package hamming_pkg;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_CORR   = 2'd1,
    ERR_UNCORR = 2'd2
  } err_kind_e;

  // Smallest P with 2^P >= data_w + P + 1 (overall parity bit excluded from P).
  function automatic int calc_par_w(input int data_w);
    int res;
    bit found;
    res   = 1;
    found = 1'b0;
    for (int p = 1; p < 8; p++) begin
      if (!found && ((1 << p) >= (data_w + p + 1))) begin
        res   = p;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Codeword position of data bit k: the k-th non-power-of-two position >= 1.
  function automatic int data_pos(input int k);
    int cnt;
    int res;
    bit found;
    cnt   = 0;
    res   = 0;
    found = 1'b0;
    for (int p = 1; p < 128; p++) begin
      if (!found && !is_pow2(p)) begin
        if (cnt == k) begin
          res   = p;
          found = 1'b1;
        end
        cnt++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome / overall-parity generator for an extended-Hamming
// codeword. Shared by the decoder front end and the encoder self-check.
module hamming_syndrome #(
  parameter int CW_W  = 16,
  parameter int PAR_W = 4
) (
  input  logic [CW_W-1:0]  cw_i,
  output logic [PAR_W-1:0] syn_o,
  output logic             op_o
);

  // Syndrome bit i covers every position 1..CW_W-1 whose index has bit i set;
  // position 0 is the overall parity bit and only enters op_o.
  always_comb begin
    syn_o = '0;
    for (int p = 1; p < CW_W; p++) begin
      for (int i = 0; i < PAR_W; i++) begin
        if (((p >> i) & 1) == 1) begin
          syn_o[i] = syn_o[i] ^ cw_i[p];
        end
      end
    end
  end

  assign op_o = ^cw_i;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SECDED decoder with valid/ready stream ports.
// Optional saturating error counters are built when HAMMING_DEC_ERR_CNT_EN is defined.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int  DATA_W = 11,
  parameter int  CNT_W  = 16,
  localparam int PAR_W  = calc_par_w(DATA_W),
  localparam int CW_W   = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_err,
  output logic [PAR_W-1:0]  out_err_pos,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  // Handshake: a word moves across a port on a rising edge where valid and
  // ready are both high. The whole pipe advances together whenever the output
  // register is empty or being drained, so in_ready follows out_ready
  // combinationally and stalled outputs stay frozen.
  logic adv;

  logic              s1_valid_q;
  logic [CW_W-1:0]   s1_cw_q;
  logic [PAR_W-1:0]  s1_syn_q;
  logic              s1_op_q;

  logic [PAR_W-1:0]  syn_d;
  logic              op_d;

  logic              s2_valid_q;
  logic [DATA_W-1:0] out_data_q;
  err_kind_e         out_err_q;
  logic [PAR_W-1:0]  out_err_pos_q;

  logic [CW_W-1:0]   corr_cw;
  logic [DATA_W-1:0] extr_data;
  logic [DATA_W-1:0] data_d;
  err_kind_e         err_d;
  logic [PAR_W-1:0]  pos_d;
  logic [31:0]       syn_ext;
  logic              syn_in_range;

  assign adv      = out_ready | ~s2_valid_q;
  assign in_ready = adv;

  hamming_syndrome #(
    .CW_W  (CW_W),
    .PAR_W (PAR_W)
  ) u_syndrome (
    .cw_i  (in_cw),
    .syn_o (syn_d),
    .op_o  (op_d)
  );

  // Stage 1: registered codeword with its syndrome and overall parity.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_syn_q   <= '0;
      s1_op_q    <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      s1_cw_q    <= in_cw;
      s1_syn_q   <= syn_d;
      s1_op_q    <= op_d;
    end
  end

  assign syn_ext      = 32'(s1_syn_q);
  assign syn_in_range = syn_ext < 32'(CW_W);

  // Classification and single-bit repair. A syndrome beyond the last
  // position can only come from a multi-bit error on shortened codes.
  always_comb begin
    corr_cw = s1_cw_q;
    err_d   = ERR_NONE;
    pos_d   = '0;
    if (s1_valid_q) begin
      if ((s1_syn_q == '0) && !s1_op_q) begin
        err_d = ERR_NONE;
      end else if (s1_op_q && syn_in_range) begin
        err_d = ERR_CORR;
        pos_d = s1_syn_q;
        for (int p = 0; p < CW_W; p++) begin
          if (syn_ext == 32'(p)) begin
            corr_cw[p] = ~s1_cw_q[p];
          end
        end
      end else begin
        err_d = ERR_UNCORR;
      end
    end
  end

  for (genvar k = 0; k < DATA_W; k++) begin : g_extract
    localparam int POS = data_pos(k);
    assign extr_data[k] = corr_cw[POS];
  end

  assign data_d = s1_valid_q ? extr_data : '0;

  // Stage 2: output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q    <= 1'b0;
      out_data_q    <= '0;
      out_err_q     <= ERR_NONE;
      out_err_pos_q <= '0;
    end else if (adv) begin
      s2_valid_q    <= s1_valid_q;
      out_data_q    <= data_d;
      out_err_q     <= err_d;
      out_err_pos_q <= pos_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_data    = out_data_q;
  assign out_err     = out_err_q;
  assign out_err_pos = out_err_pos_q;

`ifdef HAMMING_DEC_ERR_CNT_EN
  logic             out_xfer;
  logic [CNT_W-1:0] corr_cnt_q;
  logic [CNT_W-1:0] corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q;
  logic [CNT_W-1:0] uncorr_cnt_d;

  assign out_xfer = s2_valid_q & out_ready;

  // Clear wins over a coincident increment; both counters stick at all-ones.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_xfer) begin
      if ((out_err_q == ERR_CORR) && (corr_cnt_q != '1)) begin
        corr_cnt_d = corr_cnt_q + 1'b1;
      end
      if ((out_err_q == ERR_UNCORR) && (uncorr_cnt_q != '1)) begin
        uncorr_cnt_d = uncorr_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign corr_cnt       = '0;
  assign uncorr_cnt     = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Scoreboard bench for hamming_secded_decoder at DATA_W = 11 (16-bit codewords)
// with 2-bit counters; counter expectations follow HAMMING_DEC_ERR_CNT_EN.
module tb_hamming_secded_decoder;

  localparam int DATA_W = 11;
  localparam int CW_W   = 16;
  localparam int PAR_W  = 4;
  localparam int CNT_W  = 2;
  localparam int W      = DATA_W + 2 + PAR_W;
  localparam int NVEC   = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   in_cw;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_err;
  logic [PAR_W-1:0]  out_err_pos;
  logic              cnt_clr;
  logic [CNT_W-1:0]  corr_cnt;
  logic [CNT_W-1:0]  uncorr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] exp_corr   = '0;
  logic [CNT_W-1:0] exp_uncorr = '0;

  // Directed vectors: codeword, data, err class, err position (hand-computed).
  logic [CW_W-1:0]   vec_cw   [NVEC];
  logic [DATA_W-1:0] vec_data [NVEC];
  logic [1:0]        vec_err  [NVEC];
  logic [PAR_W-1:0]  vec_pos  [NVEC];

  hamming_secded_decoder #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cw       (in_cw),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_err     (out_err),
    .out_err_pos (out_err_pos),
    .cnt_clr     (cnt_clr),
    .corr_cnt    (corr_cnt),
    .uncorr_cnt  (uncorr_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [CW_W-1:0] cw, input logic [DATA_W-1:0] d,
                      input logic [1:0] e, input logic [PAR_W-1:0] p);
    logic acc;
    int   budget;
    acc    = 1'b0;
    budget = 0;
    in_valid = 1'b1;
    in_cw    = cw;
    exp_q.push_back({d, e, p});
    while (!acc && budget < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input int i);
    send(vec_cw[i], vec_data[i], vec_err[i], vec_pos[i]);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      @(posedge clk);
      b++;
    end
    #1;
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    @(negedge clk);
    check({tag, "_corr_cnt"}, 32'(corr_cnt), 32'(exp_corr));
    check({tag, "_uncorr_cnt"}, 32'(uncorr_cnt), 32'(exp_uncorr));
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    logic         xfer;
    forever begin
      @(negedge clk);
      xfer = 1'b0;
      e    = '0;
      if (rst) begin
        exp_corr   = '0;
        exp_uncorr = '0;
      end else begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_out_valid", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q[0];
            check("out_data", 32'(out_data), 32'(e[W-1:6]));
            check("out_err", 32'(out_err), 32'(e[5:4]));
            check("out_err_pos", 32'(out_err_pos), 32'(e[3:0]));
            check("in_ready_stall", 32'(in_ready), 32'(out_ready));
            if (out_ready) begin
              void'(exp_q.pop_front());
              xfer = 1'b1;
            end
          end
        end
`ifdef HAMMING_DEC_ERR_CNT_EN
        if (cnt_clr) begin
          exp_corr   = '0;
          exp_uncorr = '0;
        end else if (xfer) begin
          if (e[5:4] == 2'd1 && exp_corr != '1)   exp_corr   = exp_corr + 1'b1;
          if (e[5:4] == 2'd2 && exp_uncorr != '1) exp_uncorr = exp_uncorr + 1'b1;
        end
`endif
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_cw[0] = 16'h0000; vec_data[0] = 11'h000; vec_err[0] = 2'd0; vec_pos[0] = 4'd0;
    vec_cw[1] = 16'h0020; vec_data[1] = 11'h000; vec_err[1] = 2'd1; vec_pos[1] = 4'd5;
    vec_cw[2] = 16'h0001; vec_data[2] = 11'h000; vec_err[2] = 2'd1; vec_pos[2] = 4'd0;
    vec_cw[3] = 16'h0060; vec_data[3] = 11'h006; vec_err[3] = 2'd2; vec_pos[3] = 4'd0;
    vec_cw[4] = 16'h000F; vec_data[4] = 11'h001; vec_err[4] = 2'd0; vec_pos[4] = 4'd0;
    vec_cw[5] = 16'hFFFF; vec_data[5] = 11'h7FF; vec_err[5] = 2'd0; vec_pos[5] = 4'd0;
    vec_cw[6] = 16'hEFFF; vec_data[6] = 11'h7FF; vec_err[6] = 2'd1; vec_pos[6] = 4'd12;
    vec_cw[7] = 16'h020F; vec_data[7] = 11'h001; vec_err[7] = 2'd1; vec_pos[7] = 4'd9;
    vec_cw[8] = 16'hFFD7; vec_data[8] = 11'h7FC; vec_err[8] = 2'd2; vec_pos[8] = 4'd0;
    vec_cw[9] = 16'h000E; vec_data[9] = 11'h001; vec_err[9] = 2'd1; vec_pos[9] = 4'd0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_cw     = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_out_err_pos", 32'(out_err_pos), 32'd0);
    check("rst_corr_cnt", 32'(corr_cnt), 32'd0);
    check("rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Clean word with a latency check: valid must appear exactly two edges on.
    send_vec(0);
    @(negedge clk);
    check("latency_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_t2", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    drain();
    check_counters("clean");

    for (int i = 1; i < 4; i++) begin
      send_vec(i);
      drain();
      check_counters($sformatf("vec%0d", i));
    end

    // Back-to-back stream at full throughput.
    for (int i = 4; i < NVEC; i++) send_vec(i);
    drain();
    check_counters("stream");

    // Backpressure: consumer stalls for three cycles mid-stream.
    fork
      begin
        send_vec(5);
        send_vec(6);
        send_vec(4);
        send_vec(8);
      end
      begin
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join
    drain();
    check_counters("bp");

    // Reset while stalled with two words in flight.
    out_ready = 1'b0;
    send_vec(1);
    send_vec(3);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_corr_cnt", 32'(corr_cnt), 32'd0);
    check("midrst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    @(negedge clk);
    check("midrst_flushed", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Saturation: five corrected words into a 2-bit counter.
    for (int i = 0; i < 5; i++) send_vec(1);
    send_vec(3);
    drain();
    check_counters("sat");

    // Clear coinciding with a corrected transfer.
    cnt_clr = 1'b1;
    send_vec(2);
    drain();
    cnt_clr = 1'b0;
    check_counters("clr");
    check("clr_corr_zero", 32'(corr_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
